// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter giving a fetch port and a data/debug port shared access to one
// combinational ROM. Defining ROM_ARB_ADDR_CHECK_EN enables misaligned/out-of-range address errors.
module rom_arbiter #(
    parameter int ROM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [31:0] f_data,
    output logic        f_err,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_data,
    output logic        d_err,

    output logic [31:0] rom_address,
    input  logic [31:0] rom_result,

    output logic        o_dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic OWNER_F = 1'b0;
    localparam logic OWNER_D = 1'b1;

    if (ROM_WORDS < 1) begin : g_param_check
        $error("rom_arbiter: ROM_WORDS must be at least 1");
    end

    state_t      r_state;
    logic        r_last_owner;
    logic [31:0] r_rom_address;
    logic        r_f_gnt;
    logic        r_f_valid;
    logic [31:0] r_f_data;
    logic        r_f_err;
    logic        r_d_gnt;
    logic        r_d_valid;
    logic [31:0] r_d_data;
    logic        r_d_err;

    logic        w_f_req;
    logic        w_d_req;
    logic        w_any_req;
    logic        w_pick_d;
    logic [31:0] w_win_addr;
    logic [31:0] w_rd_data;
    logic        w_rd_err;

    // Valid handshake: a requester holds req until it sees its one-cycle gnt, and drops req in
    // the following cycle (its valid cycle). The owner's req is masked during its valid cycle so
    // a late drop never produces a second access.
    assign w_f_req   = f_req & ~r_f_valid;
    assign w_d_req   = d_req & ~r_d_valid;
    assign w_any_req = w_f_req | w_d_req;

    // On a tie the side that did not own the previous access wins.
    assign w_pick_d   = w_d_req & (~w_f_req | (r_last_owner == OWNER_F));
    assign w_win_addr = w_pick_d ? d_addr : f_addr;

`ifdef ROM_ARB_ADDR_CHECK_EN
    logic r_bad;
    logic w_win_bad;

    assign w_win_bad = (w_win_addr[1:0] != 2'b00) ||
                       ({2'b00, w_win_addr[31:2]} >= 32'(ROM_WORDS));
    assign w_rd_data = r_bad ? 32'd0 : rom_result;
    assign w_rd_err  = r_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_bad <= w_win_bad;
        end
    end
`else
    assign w_rd_data = rom_result;
    assign w_rd_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_owner  <= OWNER_D;
            r_rom_address <= 32'd0;
            r_f_gnt       <= 1'b0;
            r_f_valid     <= 1'b0;
            r_f_data      <= 32'd0;
            r_f_err       <= 1'b0;
            r_d_gnt       <= 1'b0;
            r_d_valid     <= 1'b0;
            r_d_data      <= 32'd0;
            r_d_err       <= 1'b0;
        end else begin
            r_f_gnt   <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_f_valid <= 1'b0;
            r_d_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_rom_address <= w_win_addr;
                        r_last_owner  <= w_pick_d;
                        r_f_gnt       <= ~w_pick_d;
                        r_d_gnt       <= w_pick_d;
                        r_state       <= READ;
                    end
                end
                READ: begin
                    if (r_last_owner == OWNER_D) begin
                        r_d_valid <= 1'b1;
                        r_d_data  <= w_rd_data;
                        r_d_err   <= w_rd_err;
                    end else begin
                        r_f_valid <= 1'b1;
                        r_f_data  <= w_rd_data;
                        r_f_err   <= w_rd_err;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign f_gnt       = r_f_gnt;
    assign f_valid     = r_f_valid;
    assign f_data      = r_f_data;
    assign f_err       = r_f_err;
    assign d_gnt       = r_d_gnt;
    assign d_valid     = r_d_valid;
    assign d_data      = r_d_data;
    assign d_err       = r_d_err;
    assign rom_address = r_rom_address;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: per-cycle vector table plus hand sequences for tie-break,
// continuous alternation, owner-req masking and reset during an access.
`timescale 1ns/1ps
module tb_rom_arbiter;

    localparam int ROM_WORDS = 128;
`ifdef ROM_ARB_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'd0;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic        f_gnt, f_valid, f_err;
    logic [31:0] f_data;
    logic        d_gnt, d_valid, d_err;
    logic [31:0] d_data;
    logic [31:0] rom_address;
    logic [31:0] rom_result;
    logic        dbg_state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.ROM_WORDS(ROM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
        .f_data(f_data), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid),
        .d_data(d_data), .d_err(d_err),
        .rom_address(rom_address), .rom_result(rom_result),
        .o_dbg_state(dbg_state)
    );

    // ROM contents: word i holds 0x20080004 + i (so word1 = 0x20080005).
    function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
        return 32'h20080004 + (byte_addr >> 2);
    endfunction

    always_comb rom_result = rom_word(rom_address);

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic [31:0] da;
        logic [1:0]  gnt;   // {d,f}
        logic [1:0]  vld;   // {d,f}
        logic [31:0] fd;
        logic [31:0] dd;
        logic        fe;
        logic        de;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da,
                       input logic [1:0] g, input logic [1:0] v, input logic [31:0] fd,
                       input logic [31:0] dd, input logic fe, input logic de);
        vec_t e;
        e.fr = fr; e.fa = fa; e.dr = dr; e.da = da; e.gnt = g; e.vld = v;
        e.fd = fd; e.dd = dd; e.fe = fe; e.de = de;
        vq.push_back(e);
    endtask

    // Drive inputs just after a rising edge, then wait to the falling edge for sampling.
    task automatic next_cycle(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        @(negedge clk);
    endtask

    task automatic do_reset();
        f_req = 1'b0; f_addr = 32'd0; d_req = 1'b0; d_addr = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, d_gnt, f_gnt}, 32'd0);
        chk({tag, "_vld"}, {30'd0, d_valid, f_valid}, 32'd0);
        chk({tag, "_err"}, {30'd0, d_err, f_err}, 32'd0);
        chk({tag, "_fdata"}, f_data, 32'd0);
        chk({tag, "_ddata"}, d_data, 32'd0);
        chk({tag, "_romaddr"}, rom_address, 32'd0);
        chk({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        logic [31:0] e11, e14, e21;
        logic        seen_f, seen_d;
        logic [1:0]  exp_g;

        e11 = CHK ? 32'd0 : rom_word(32'd3);
        e14 = CHK ? 32'd0 : rom_word(32'd1000);
        e21 = CHK ? 32'd0 : rom_word(32'd512);

        //   fr fa        dr da         gnt    vld    f_data             d_data             fe   de
        add(1, 32'd4,   0, 32'd0,    2'b00, 2'b00, 32'd0,             32'd0,             0,   0);
        add(1, 32'd4,   0, 32'd0,    2'b01, 2'b00, 32'd0,             32'd0,             0,   0);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b01, 32'h20080005,      32'd0,             0,   0);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b00, 32'h20080005,      32'd0,             0,   0);
        add(1, 32'd8,   1, 32'd12,   2'b00, 2'b00, 32'h20080005,      32'd0,             0,   0);
        add(1, 32'd8,   1, 32'd12,   2'b10, 2'b00, 32'h20080005,      32'd0,             0,   0);
        add(1, 32'd8,   0, 32'd0,    2'b00, 2'b10, 32'h20080005,      32'h20080007,      0,   0);
        add(1, 32'd8,   0, 32'd0,    2'b01, 2'b00, 32'h20080005,      32'h20080007,      0,   0);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b01, 32'h20080006,      32'h20080007,      0,   0);
        add(1, 32'd3,   0, 32'd0,    2'b00, 2'b00, 32'h20080006,      32'h20080007,      0,   0);
        add(1, 32'd3,   0, 32'd0,    2'b01, 2'b00, 32'h20080006,      32'h20080007,      0,   0);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b01, e11,               32'h20080007,      CHK, 0);
        add(0, 32'd0,   1, 32'd1000, 2'b00, 2'b00, e11,               32'h20080007,      CHK, 0);
        add(0, 32'd0,   1, 32'd1000, 2'b10, 2'b00, e11,               32'h20080007,      CHK, 0);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b10, e11,               e14,               CHK, CHK);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b00, e11,               e14,               CHK, CHK);
        add(0, 32'd0,   1, 32'd508,  2'b00, 2'b00, e11,               e14,               CHK, CHK);
        add(0, 32'd0,   1, 32'd508,  2'b10, 2'b00, e11,               e14,               CHK, CHK);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b10, e11,               32'h20080083,      CHK, 0);
        add(1, 32'd512, 0, 32'd0,    2'b00, 2'b00, e11,               32'h20080083,      CHK, 0);
        add(1, 32'd512, 0, 32'd0,    2'b01, 2'b00, e11,               32'h20080083,      CHK, 0);
        add(0, 32'd0,   0, 32'd0,    2'b00, 2'b01, e21,               32'h20080083,      CHK, 0);

        #1;
        rst_n = 1'b0;
        #2;
        chk_all_zero("reset");
        do_reset();

        foreach (vq[i]) begin
            next_cycle(vq[i].fr, vq[i].fa, vq[i].dr, vq[i].da);
            chk($sformatf("v%0d_gnt", i), {30'd0, d_gnt, f_gnt}, {30'd0, vq[i].gnt});
            chk($sformatf("v%0d_vld", i), {30'd0, d_valid, f_valid}, {30'd0, vq[i].vld});
            chk($sformatf("v%0d_fdata", i), f_data, vq[i].fd);
            chk($sformatf("v%0d_ddata", i), d_data, vq[i].dd);
            chk($sformatf("v%0d_ferr", i), {31'd0, f_err}, {31'd0, vq[i].fe});
            chk($sformatf("v%0d_derr", i), {31'd0, d_err}, {31'd0, vq[i].de});
        end

        // Tie straight after reset: fetch first, data granted in cycle 3, d_valid in cycle 4.
        do_reset();
        next_cycle(1, 32'd8, 1, 32'd12);
        chk("tie_c0_gnt", {30'd0, d_gnt, f_gnt}, 32'd0);
        next_cycle(1, 32'd8, 1, 32'd12);
        chk("tie_c1_gnt", {30'd0, d_gnt, f_gnt}, 32'd1);
        next_cycle(0, 32'd0, 1, 32'd12);
        chk("tie_c2_fvalid", {31'd0, f_valid}, 32'd1);
        chk("tie_c2_fdata", f_data, 32'h20080006);
        chk("tie_c2_gnt", {30'd0, d_gnt, f_gnt}, 32'd0);
        next_cycle(0, 32'd0, 1, 32'd12);
        chk("tie_c3_gnt", {30'd0, d_gnt, f_gnt}, 32'd2);
        next_cycle(0, 32'd0, 0, 32'd0);
        chk("tie_c4_dvalid", {31'd0, d_valid}, 32'd1);
        chk("tie_c4_ddata", d_data, 32'h20080007);

        // Both sides re-requesting continuously: grants alternate f,d,f,d every 2 cycles.
        do_reset();
        seen_f = 1'b0;
        seen_d = 1'b0;
        for (int c = 0; c < 10; c++) begin
            next_cycle(~seen_f, 32'd16, ~seen_d, 32'd20);
            if (c % 2 == 1) exp_g = (((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            else            exp_g = 2'b00;
            chk($sformatf("rr_c%0d_gnt", c), {30'd0, d_gnt, f_gnt}, {30'd0, exp_g});
            seen_f = f_gnt;
            seen_d = d_gnt;
        end

        // Owner holding req through its valid cycle must not get a second access.
        do_reset();
        next_cycle(1, 32'd4, 0, 32'd0);
        next_cycle(1, 32'd4, 0, 32'd0);
        chk("hold_c1_gnt", {30'd0, d_gnt, f_gnt}, 32'd1);
        next_cycle(1, 32'd4, 0, 32'd0);
        chk("hold_c2_fvalid", {31'd0, f_valid}, 32'd1);
        next_cycle(0, 32'd0, 0, 32'd0);
        chk("hold_c3_gnt", {30'd0, d_gnt, f_gnt}, 32'd0);
        chk("hold_c3_state", {31'd0, dbg_state}, 32'd0);

        // Reset asserted during READ: outputs clear at once, no valid afterwards.
        next_cycle(1, 32'd12, 0, 32'd0);
        next_cycle(1, 32'd12, 0, 32'd0);
        chk("rsr_gnt", {30'd0, d_gnt, f_gnt}, 32'd1);
        chk("rsr_state", {31'd0, dbg_state}, 32'd1);
        #2;
        rst_n = 1'b0;
        f_req = 1'b0;
        #1;
        chk_all_zero("rsr_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle(0, 32'd0, 0, 32'd0);
            chk($sformatf("rsr_idle%0d_vld", c), {30'd0, d_valid, f_valid}, 32'd0);
        end
        next_cycle(0, 32'd0, 1, 32'd20);
        chk("rsr_new_c0_gnt", {30'd0, d_gnt, f_gnt}, 32'd0);
        next_cycle(0, 32'd0, 1, 32'd20);
        chk("rsr_new_c1_gnt", {30'd0, d_gnt, f_gnt}, 32'd2);
        next_cycle(0, 32'd0, 0, 32'd0);
        chk("rsr_new_c2_dvalid", {31'd0, d_valid}, 32'd1);
        chk("rsr_new_c2_ddata", d_data, 32'h20080009);
        chk("rsr_new_c2_derr", {31'd0, d_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter: ROM_WORDS, 1024, number of 32-bit words in the attached Rom; valid word index range 0..ROM_WORDS-1.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: f_req  input  1  fetch-side request, held until f_gnt seen.
REQ-006 SHALL have port: f_addr  input  32  fetch byte address, stable while f_req high.
REQ-007 SHALL have port: f_gnt  output  1  fetch grant pulse.
REQ-008 SHALL have port: f_valid  output  1  fetch response strobe.
REQ-009 SHALL have port: f_data  output  32  fetch response word.
REQ-010 SHALL have port: f_err  output  1  fetch address error, qualified by f_valid.
REQ-011 SHALL have ports d_req, d_addr, d_gnt, d_valid, d_data, d_err with the same directions, widths and meanings for the data/debug side.
REQ-012 SHALL have port: rom_address  output  32  byte address to the Rom address input.
REQ-013 SHALL have port: rom_result  input  32  combinational Rom read word.

Function
REQ-014 SHALL implement FSM states IDLE and READ.
REQ-015 IDLE: with no request, SHALL stay in IDLE.
REQ-016 IDLE: with any request, on the next edge SHALL latch the winner's address into rom_address, record the owner, pulse the winner's gnt high for exactly one cycle, and enter READ.
REQ-017 READ: on the next edge SHALL capture rom_result into the owner's data register, pulse the owner's valid high for exactly one cycle, and return to IDLE unconditionally.
REQ-018 Latency SHALL be: req high in cycle 0 (IDLE) -> gnt high in cycle 1 -> valid high with data in cycle 2.
REQ-019 Throughput SHALL be one access per 2 cycles; the next grant is issued no earlier than the valid cycle.
REQ-020 Requesters SHALL drop req in the cycle after seeing gnt; the arbiter SHALL ignore the owner's req during the valid cycle.
REQ-021 Arbitration SHALL be round-robin over a 1-bit last_owner: when both request in IDLE, grant the side not equal to last_owner; a single requester always wins.
REQ-022 gnt and valid SHALL never be high for both sides in the same cycle, and f_gnt/d_gnt SHALL be mutually exclusive.
REQ-023 data and err outputs SHALL hold their values until that side's next valid.
REQ-024 rom_address SHALL hold the last latched address while in IDLE.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, last_owner to data side (fetch wins the first tie), and all outputs (gnt, valid, err, data, rom_address) to 0, independent of clk.
REQ-026 An access in flight at reset SHALL be abandoned with no valid pulse after release.
REQ-027 The first grant SHALL occur no earlier than the first rising edge after rst_n goes high.

Configuration
REQ-028 Macro ROM_ARB_ADDR_CHECK_EN SHALL control address checking.
REQ-029 With ROM_ARB_ADDR_CHECK_EN defined, an access with addr[1:0] != 0 or addr[31:2] >= ROM_WORDS SHALL complete with the normal timing, err=1 and data=0; legal accesses SHALL have err=0.
REQ-030 Without ROM_ARB_ADDR_CHECK_EN, the address SHALL pass through unchecked, data SHALL equal rom_result, and f_err/d_err SHALL be constant 0.

Verification
REQ-031 Reset release, f_req with f_addr=4, ROM word1=0x20080005 -> f_gnt high in cycle 1, f_valid high in cycle 2 with f_data=0x20080005, f_err=0.
REQ-032 After reset, f_req (addr 8) and d_req (addr 12) raised together -> fetch granted first, data granted at cycle 3; d_valid in cycle 4 carries ROM word3.
REQ-033 Both sides requesting continuously (requests re-raised after each valid) -> grants alternate f,d,f,d with 2-cycle spacing and no simultaneous gnt.
REQ-034 With the macro defined: f_addr=3 -> f_err=1, f_data=0; with ROM_WORDS=128, d_addr=1000 -> d_err=1. Without the macro: f_addr=3 -> f_err=0.
REQ-035 rst_n pulsed low during READ -> all outputs read 0 immediately; no valid pulse follows; a new request after release is served with the normal 2-cycle latency.
